// File: rtl/mac_round_sat.sv
// mac_round_sat: 3-stage signed multiply-accumulate with round-half-up and saturation.
module mac_round_sat #(
  parameter int A_W       = 40,
  parameter int B_W       = 13,
  parameter int C_W       = 22,
  parameter int C_SHIFT   = 0,
  parameter int RND_SHIFT = 0,
  parameter int OUT_W     = 54
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [C_W-1:0]   c,
  input  logic             sub,
  output logic             out_valid,
  output logic [OUT_W-1:0] data_out,
  output logic             sat_flag,
  output logic             ovf_sticky,
  input  logic             clr_ovf
);
  localparam int PW = A_W + B_W;
  localparam int SW = PW + 2;
  localparam int XW = SW > OUT_W ? SW : OUT_W;
  localparam logic [SW:0] RND_W = (SW+1)'(1) << RND_SHIFT;
  localparam logic signed [SW-1:0] RND_C = $signed(RND_W[SW:1]);
  localparam logic signed [XW-1:0] MAXV = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = ~MAXV;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic [C_W-1:0] c_q, c_d, c2_q, c2_d;
  logic sub_q, sub_d, sub2_q, sub2_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [PW-1:0] p_q, p_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic sat_q, sat_d, ovf_q, ovf_d;
  logic signed [SW-1:0] c_ext, s, r;
  logic signed [XW-1:0] r_x;
  logic sat_hi, sat_lo;
  always_comb begin
    c_ext  = SW'($signed(c2_q)) <<< C_SHIFT;
    s      = sub2_q ? SW'($signed(p_q)) - c_ext : SW'($signed(p_q)) + c_ext;
    r      = (s + RND_C) >>> RND_SHIFT;
    r_x    = XW'(r);
    sat_hi = r_x > MAXV;
    sat_lo = r_x < MINV;
    a_d    = ce ? a : a_q;
    b_d    = ce ? b : b_q;
    c_d    = ce ? c : c_q;
    sub_d  = ce ? sub : sub_q;
    v1_d   = ce ? in_valid : v1_q;
    p_d    = ce ? PW'(PW'($signed(a_q)) * PW'($signed(b_q))) : p_q;
    c2_d   = ce ? c_q : c2_q;
    sub2_d = ce ? sub_q : sub2_q;
    v2_d   = ce ? v1_q : v2_q;
    dout_d = !ce ? dout_q : sat_hi ? MAXV[OUT_W-1:0] : sat_lo ? MINV[OUT_W-1:0] : r_x[OUT_W-1:0];
    sat_d  = ce ? (sat_hi | sat_lo) : sat_q;
    v3_d   = ce ? v2_q : v3_q;
    // a saturating result landing in the same cycle as a clear keeps the flag set
    ovf_d  = (ce & v2_q & (sat_hi | sat_lo)) | (ovf_q & ~clr_ovf);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q <= '0; b_q <= '0; c_q <= '0; sub_q <= 1'b0; v1_q <= 1'b0;
      p_q <= '0; c2_q <= '0; sub2_q <= 1'b0; v2_q <= 1'b0;
      dout_q <= '0; sat_q <= 1'b0; v3_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      a_q <= a_d; b_q <= b_d; c_q <= c_d; sub_q <= sub_d; v1_q <= v1_d;
      p_q <= p_d; c2_q <= c2_d; sub2_q <= sub2_d; v2_q <= v2_d;
      dout_q <= dout_d; sat_q <= sat_d; v3_q <= v3_d; ovf_q <= ovf_d;
    end
  end
  assign out_valid  = v3_q;
  assign data_out   = dout_q;
  assign sat_flag   = sat_q;
  assign ovf_sticky = ovf_q;
endmodule

// File: tb/tb_mac_round_sat.sv
// tb_mac_round_sat: directed and random checks of two mac_round_sat configurations against an arithmetic model.
module tb_mac_round_sat;
  logic clk, rst, ce, iv, sub, clr;
  logic [39:0] a;
  logic [12:0] b;
  logic [21:0] c;
  logic ov0, sat0, st0, ov1, sat1, st1;
  logic [53:0] d0;
  logic [15:0] d1;
  int total = 0, passed = 0;
  typedef struct {int n; longint e0; bit s0; longint e1; bit s1;} ent_t;
  ent_t q[$];
  ent_t cur;
  bit ev, est0, est1;
  int en_cnt = 0;

  mac_round_sat u0 (.clock(clk), .reset(rst), .ce(ce), .in_valid(iv), .a(a), .b(b), .c(c), .sub(sub),
    .out_valid(ov0), .data_out(d0), .sat_flag(sat0), .ovf_sticky(st0), .clr_ovf(clr));
  mac_round_sat #(.OUT_W(16), .RND_SHIFT(4)) u1 (.clock(clk), .reset(rst), .ce(ce), .in_valid(iv), .a(a), .b(b),
    .c(c), .sub(sub), .out_valid(ov1), .data_out(d1), .sat_flag(sat1), .ovf_sticky(st1), .clr_ovf(clr));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void model(input logic [39:0] ai, input logic [12:0] bi, input logic [21:0] ci, input bit sb,
                                input int rnd, input int ow, output longint d, output bit s);
    longint p, sm, r, mx, mn;
    p  = longint'($signed(ai)) * longint'($signed(bi));
    sm = sb ? p - longint'($signed(ci)) : p + longint'($signed(ci));
    r  = rnd == 0 ? sm : (sm + (64'sd1 <<< (rnd - 1))) >>> rnd;
    mx = (64'sd1 <<< (ow - 1)) - 1;
    mn = -mx - 1;
    s  = r > mx || r < mn;
    d  = r > mx ? mx : r < mn ? mn : r;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("out_valid0", longint'(ov0), longint'(ev));
    chk("out_valid1", longint'(ov1), longint'(ev));
    chk("sticky0", longint'(st0), longint'(est0));
    chk("sticky1", longint'(st1), longint'(est1));
    if (ev) begin
      chk("data0", longint'($signed(d0)), cur.e0);
      chk("sat0", longint'(sat0), longint'(cur.s0));
      chk("data1", longint'($signed(d1)), cur.e1);
      chk("sat1", longint'(sat1), longint'(cur.s1));
    end
  endtask

  task automatic step(input bit ce_i, input bit iv_i, input logic [39:0] a_i, input logic [12:0] b_i,
                      input logic [21:0] c_i, input bit sub_i, input bit clr_i);
    ent_t e;
    ce = ce_i; iv = iv_i; a = a_i; b = b_i; c = c_i; sub = sub_i; clr = clr_i;
    @(posedge clk);
    #1;
    if (ce_i) begin
      en_cnt++;
      if (iv_i) begin
        e.n = en_cnt;
        model(a_i, b_i, c_i, sub_i, 0, 54, e.e0, e.s0);
        model(a_i, b_i, c_i, sub_i, 4, 16, e.e1, e.s1);
        q.push_back(e);
      end
      ev = q.size() > 0 && q[0].n == en_cnt - 2;
      if (ev) cur = q.pop_front();
    end
    if (ce_i && ev && cur.s0) est0 = 1; else if (clr_i) est0 = 0;
    if (ce_i && ev && cur.s1) est1 = 1; else if (clr_i) est1 = 0;
    check_all();
  endtask

  task automatic rstep(input bit ce_i, input bit iv_i, input bit clr_i);
    step(ce_i, iv_i, 40'({$urandom, $urandom}), 13'($urandom), 22'($urandom), 1'($urandom), clr_i);
  endtask

  task automatic reset_checks();
    chk("rst_valid0", longint'(ov0), 0);
    chk("rst_valid1", longint'(ov1), 0);
    chk("rst_data0", longint'(d0), 0);
    chk("rst_data1", longint'(d1), 0);
    chk("rst_sat1", longint'(sat1), 0);
    chk("rst_sticky0", longint'(st0), 0);
    chk("rst_sticky1", longint'(st1), 0);
  endtask

  initial begin
    rst = 1; ce = 0; iv = 0; a = 0; b = 0; c = 0; sub = 0; clr = 0;
    ev = 0; est0 = 0; est1 = 0;
    #12;
    reset_checks();
    rst = 0;
    // small product plus addend, then the subtract variant
    step(1, 1, 40'd3, 13'(-2), 22'd5, 0, 0);
    repeat (4) step(1, 0, 40'd0, 13'd0, 22'd0, 0, 0);
    step(1, 1, 40'd3, 13'(-2), 22'd5, 1, 0);
    repeat (4) step(1, 0, 40'd0, 13'd0, 22'd0, 0, 0);
    // ten back-to-back samples with a two-cycle stall in the middle
    for (int i = 0; i < 10; i++) begin
      if (i == 5) repeat (2) rstep(0, 1, 0);
      rstep(1, 1, 0);
    end
    repeat (4) rstep(1, 0, 0);
    // rounding behaviour of the narrow configuration
    step(1, 1, 40'd100, 13'd7, 22'd13, 0, 0);
    step(1, 1, 40'd100, 13'd7, 22'd9, 0, 0);
    repeat (4) rstep(1, 0, 0);
    // positive and negative saturation, sticky held until cleared
    step(1, 1, 40'd1048576, 13'd1, 22'd0, 0, 0);
    step(1, 1, 40'(-1048576), 13'd1, 22'd0, 0, 0);
    repeat (5) rstep(1, 0, 0);
    rstep(0, 0, 1);
    rstep(1, 0, 0);
    // clear coinciding with a saturating result at the output stage
    step(1, 1, 40'd1048576, 13'd1, 22'd0, 0, 0);
    rstep(1, 0, 0);
    rstep(1, 0, 1);
    rstep(1, 0, 1);
    rstep(1, 0, 0);
    repeat (60) rstep(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0));
    repeat (4) rstep(1, 0, 0);
    // reset with samples in flight
    step(1, 1, 40'd1048576, 13'd1, 22'd0, 0, 0);
    step(1, 1, 40'd1048576, 13'd1, 22'd0, 0, 0);
    #2 rst = 1;
    #1 reset_checks();
    #3 rst = 0;
    q.delete(); ev = 0; est0 = 0; est1 = 0;
    repeat (5) rstep(1, 0, 0);
    step(1, 1, 40'd3, 13'(-2), 22'd5, 0, 0);
    repeat (4) rstep(1, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
